// File: rtl/spi_register_bus_master.sv
// SPI mode-0 slave front end that turns host command/data frames into register-bus
// writes (_HOLD strobe) and reads (ReadData captured into the MISO shifter).
module spi_register_bus_master #(
    parameter int unsigned AddressWidth = 7,
    parameter int unsigned BitWidth     = 8
) (
    input  logic                    CLK,
    input  logic                    _RST,
    input  logic                    SCK,
    input  logic                    MOSI,
    input  logic                    _CS,
    output logic                    MISO,
    output logic                    MISO_OE,
    output logic [AddressWidth-1:0] AddressBus,
    output logic [BitWidth-1:0]     BusData,
    input  logic [BitWidth-1:0]     ReadData,
    output logic                    _HOLD
);

    // Receive shifter must hold a full command byte or a full data word.
    localparam int unsigned ShiftWidth = (BitWidth > 8) ? BitWidth : 8;
    localparam int unsigned CntWidth   = 5;
    localparam logic [CntWidth-1:0] LastCmdBit  = CntWidth'(7);
    localparam logic [CntWidth-1:0] LastDataBit = CntWidth'(BitWidth - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StData,
        StWstrobe,
        StRdload
    } state_e;

    logic [2:0] sck_sync_q;
    logic [1:0] mosi_sync_q;
    logic [1:0] cs_sync_q;

    logic sck_rise;
    logic sck_fall;
    logic cs_n;
    logic mosi_bit;

    state_e                  state_q, state_d;
    logic [CntWidth-1:0]     bit_cnt_q, bit_cnt_d;
    logic [ShiftWidth-2:0]   rx_q, rx_d;
    logic [ShiftWidth-1:0]   rx_next;
    logic [BitWidth-1:0]     tx_q, tx_d;
    logic [AddressWidth-1:0] addr_q, addr_d;
    logic [BitWidth-1:0]     data_q, data_d;
    logic                    is_read_q, is_read_d;
    logic                    hold_n_q, hold_n_d;
    logic                    miso_oe_q, miso_oe_d;
    logic                    rd_wait_q, rd_wait_d;

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '1;
        end else begin
            sck_sync_q  <= {sck_sync_q[1:0], SCK};
            mosi_sync_q <= {mosi_sync_q[0], MOSI};
            cs_sync_q   <= {cs_sync_q[0], _CS};
        end
    end

    assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
    assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
    assign cs_n     = cs_sync_q[1];
    assign mosi_bit = mosi_sync_q[1];
    assign rx_next  = {rx_q, mosi_bit};

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            is_read_q <= 1'b0;
            hold_n_q  <= 1'b1;
            miso_oe_q <= 1'b0;
            rd_wait_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            is_read_q <= is_read_d;
            hold_n_q  <= hold_n_d;
            miso_oe_q <= miso_oe_d;
            rd_wait_q <= rd_wait_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        addr_d    = addr_q;
        data_d    = data_q;
        is_read_d = is_read_q;
        hold_n_d  = hold_n_q;
        miso_oe_d = miso_oe_q;
        rd_wait_d = rd_wait_q;

        unique case (state_q)
            StIdle: begin
                if (!cs_n) begin
                    state_d   = StCmd;
                    bit_cnt_d = '0;
                end
            end
            StCmd: begin
                if (sck_rise) begin
                    rx_d      = rx_next[ShiftWidth-2:0];
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LastCmdBit) begin
                        bit_cnt_d = '0;
                        is_read_d = rx_next[7];
                        addr_d    = rx_next[AddressWidth-1:0];
                        if (rx_next[7]) begin
                            state_d   = StRdload;
                            rd_wait_d = 1'b1;
                            miso_oe_d = 1'b1;
                        end else begin
                            state_d = StData;
                        end
                    end
                end
            end
            StData: begin
                if (sck_rise) begin
                    rx_d      = rx_next[ShiftWidth-2:0];
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LastDataBit) begin
                        bit_cnt_d = '0;
                        if (is_read_q) begin
                            addr_d    = addr_q + 1'b1;
                            state_d   = StRdload;
                            rd_wait_d = 1'b1;
                        end else begin
                            data_d   = rx_next[BitWidth-1:0];
                            hold_n_d = 1'b0;
                            state_d  = StWstrobe;
                        end
                    end
                end
                // The falling edge that closes a frame (count back at 0) must not
                // shift, or the freshly loaded MSB would be lost.
                if (sck_fall && is_read_q && (bit_cnt_q != '0)) begin
                    tx_d = tx_q << 1;
                end
            end
            StWstrobe: begin
                hold_n_d = 1'b1;
                addr_d   = addr_q + 1'b1;
                state_d  = StData;
            end
            StRdload: begin
                // One settle cycle after the address moves before ReadData is taken.
                if (rd_wait_q) begin
                    rd_wait_d = 1'b0;
                end else begin
                    tx_d    = ReadData;
                    state_d = StData;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if ((state_q != StIdle) && cs_n) begin
            state_d   = StIdle;
            bit_cnt_d = '0;
            addr_d    = addr_q;
            data_d    = data_q;
            hold_n_d  = 1'b1;
            miso_oe_d = 1'b0;
            rd_wait_d = 1'b0;
        end
    end

    assign MISO       = tx_q[BitWidth-1];
    assign MISO_OE    = miso_oe_q;
    assign AddressBus = addr_q;
    assign BusData    = data_q;
    assign _HOLD      = hold_n_q;

endmodule

// File: doc/spi_register_bus_master.md
# spi_register_bus_master

Serial-to-register-bus front end for the PWM IO expander. Receives SPI mode-0 frames from the host, decodes a command byte into an address and direction, then drives the shared register bus: it presents AddressBus and write data, pulses the active-low _HOLD write strobe for writes, and captures the resolved read bus for reads. Burst transfers auto-increment the address. This block is the single initiator for every addressable register in the design.

## Interface
- AddressWidth, 7, register-bus address width; legal 1..7. It occupies command bits [AddressWidth-1:0].
- BitWidth, 8, register data width and data-frame length in SCK bits; legal 1..16.
- CLK  in  1  system clock; all logic is on the rising edge.
- _RST  in  1  asynchronous, active-low reset.
- SCK  in  1  host serial clock, asynchronous to CLK; synchronized internally with 2 flops.
- MOSI  in  1  host data, synchronized alongside SCK.
- _CS  in  1  host chip select, active-low, synchronized alongside SCK.
- MISO  out  1  serial read data, MSB first.
- MISO_OE  out  1  high while _CS (synchronized) is low and the frame is a read.
- AddressBus  out  AddressWidth  register-bus address.
- BusData  out  BitWidth  write data to the registers' DataIn.
- ReadData  in  BitWidth  resolved register read bus; high-Z bits are read as 0 by the bench.
- _HOLD  out  1  active-low write strobe; low for exactly one CLK per written data frame.

## Operation
- Framing: MSB first. MOSI is sampled on each synchronized SCK rising edge. MISO shifts on each synchronized SCK falling edge.
- First 8 bits of a frame form the command byte. Bit 7: 1 = read, 0 = write. Bits [AddressWidth-1:0] are the start address. Other bits are ignored.
- Each following group of BitWidth bits is one data frame.
- States:
  - IDLE: _CS high. Wait for _CS low, then go to CMD.
  - CMD: count 8 rising edges, then latch address and direction and go to DATA. For a read, go via RDLOAD.
  - DATA: count BitWidth rising edges. For a write, go to WSTROBE. For a read, go to RDLOAD.
  - WSTROBE: drive _HOLD low for one cycle, then return to DATA.
  - RDLOAD: sample ReadData into the MISO shifter, then return to DATA.
- Write burst: each completed data frame is written to AddressBus, then the address increments.
- Read burst: the word at the current address is loaded before its frame. After the frame completes, the address increments and the next word is loaded. MOSI data during a read is discarded.
- Address increment wraps modulo 2^AddressWidth; e.g. 7'h7F goes to 7'h00.
- _CS rising (synchronized) in any state:
  - Discard any partial command or data frame; no _HOLD pulse results.
  - Go to IDLE and drop MISO_OE on the next CLK.
  - AddressBus and BusData hold their last values.
- _CS high→low→high with fewer than 8 SCK edges: no bus activity.
- Reset, including mid-frame or while _HOLD is low: asynchronous return to IDLE. Outputs take their reset values immediately, and the bit counters clear.

## Timing
- Reset values: AddressBus=0, BusData=0, _HOLD=1, MISO=0, MISO_OE=0.
- Input latency: SCK, MOSI and _CS pass 2 sync flops, then edge detection.
- Let T be the cycle in which the last rising edge of a frame is detected.
- Write frame:
  - T+1: BusData = received word; AddressBus unchanged; _HOLD=0.
  - T+2: _HOLD=1; AddressBus increments.
  - A register captures on the CLK edge that ends cycle T+1.
- Read command: at T+1, AddressBus = start address and MISO_OE=1. ReadData is sampled at the end of T+2, and MISO = word MSB from T+3.
- Read data frame: the address increments at T+1, and reload follows the same T+2/T+3 pattern.
- Requirement: CLK ≥ 8× SCK, with SCK low time ≥ 4 CLK, so the MSB is valid before the host's first sampling edge.
- _HOLD is never low in two consecutive cycles and never low while _CS is high.

## Test plan
- Reset: assert _RST=0 mid-frame → AddressBus=0, BusData=0, _HOLD=1, MISO_OE=0 immediately; after release, the next full frame works normally.
- Single write: command 8'h05, data 8'hA5 → one _HOLD low cycle with AddressBus=5 and BusData=A5; then AddressBus=6.
- Write burst with wrap: command 8'h7F, data 11, 22 → writes 11@7F, then 22@00, each with a single _HOLD pulse.
- Read burst: command 8'h83 with ReadData model returning addr^8'h3C → MISO shifts 3F then 38, MISO_OE=1 throughout, _HOLD stays 1.
- Abort: _CS raised after 4 bits of a write data frame → no _HOLD pulse, state IDLE, next frame 8'h02/8'h77 writes 77@02.
- Short frame: _CS low with 5 SCK edges, then high → no _HOLD pulse and AddressBus unchanged.
